res_pack: RTL
=============

Name: res_pack

Overview:
- Reverse-direction companion to the distance-transform engine: reads the 128x128 8-bit result map from the res memory and thresholds each pixel to one bit.
- Packs the bits into 16-bit words in the same layout the transform engine reads from sti, and writes them out through a sti-style write port.
- Used to regenerate or erode a binary image from a distance map, and to count object pixels.

Parameters:
- THRESH, 8'd1, a pixel is object (1) when res_di >= THRESH, otherwise background (0).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a full-image pass; sampled only in IDLE or FINISH.
- busy  out  1  high in READ and FLUSH.
- done  out  1  high in FINISH; held until the next accepted start.
- res_rd  out  1  res memory read strobe (registered).
- res_addr  out  14  pixel address, y*128+x (registered).
- res_di  in  8  res read data.
- sti_wr  out  1  one-cycle write strobe for a packed word (registered).
- sti_addr  out  10  word address, y*8+x[6:4] (registered).
- sti_do  out  16  packed word; pixel with x[3:0]=k sits at bit 15-k (registered).
- obj_cnt  out  15  number of object pixels found in the current or last pass.

Behaviour:
- Reset (async, reset=1): state IDLE; busy=0, done=0, res_rd=0, res_addr=0, sti_wr=0, sti_addr=0, sti_do=0, obj_cnt=0; shift register, bit counter and pipeline-valid cleared. Asserting reset mid-pass aborts the pass immediately, with no partial write.
- States: IDLE, READ, FLUSH, FINISH.
- IDLE / FINISH: start=1 at an edge -> READ. At that same edge: res_addr<=0, res_rd<=1, obj_cnt<=0, done<=0.
- READ:
  - One read per cycle, no bubbles. res_addr increments by 1 each edge while res_rd=1.
  - When res_addr==16383 is being driven, the next edge sets res_rd<=0 and moves to FLUSH.
- Memory timing: res_di for the address driven in cycle n is valid in cycle n+1. The block samples it at the end of cycle n+1 via a 1-bit valid pipeline that tracks res_rd.
- Packing (on each valid sample):
  - bit = (res_di >= THRESH).
  - shift <= {shift[14:0], bit}.
  - obj_cnt += bit.
  - bit counter 4-bit, wraps from 15 to 0.
- On the 16th valid sample of a word, the same edge registers:
  - sti_do <= {shift[14:0], bit};
  - sti_addr <= word index (0..1023, incremented after each write);
  - sti_wr <= 1.
  sti_wr then drops to 0 at the following edge unless another word completes. At one read per cycle this cannot happen, so sti_wr is always a single-cycle pulse spaced exactly 16 cycles apart.
- FLUSH: waits for the final valid sample and the final write (word 1023), then moves to FINISH on the edge after the final sti_wr pulse.
- FINISH: done=1, busy=0. obj_cnt holds the final count until the next start.
- Latency: first sti_wr is 17 cycles after the start edge. done rises 16386 cycles after the start edge.
- Simultaneous events:
  - start while busy is ignored.
  - start in FINISH restarts the pass; done falls at that edge.
- Width rules:
  - obj_cnt cannot overflow (max 16384 would need 15 bits; 16384 = 15'h4000, representable).
  - sti_addr wraps to 0 after 1023, but no write follows in the same pass.
  - Threshold compare is unsigned 8-bit; THRESH=0 makes every pixel object.

Test Plan:
- All res cells 0, THRESH=1, pulse start -> 1024 sti_wr pulses, each with sti_do=16'h0000 and sti_addr 0..1023 in order; obj_cnt=0; done high; busy low.
- All res cells 8'hFF -> every sti_do=16'hFFFF, obj_cnt=16384 (15'h4000).
- res[a]=a[7:0], THRESH=1 -> word 0 = 16'h7FFF, word 8 (row 1, x 0..15, values 128..143) = 16'hFFFF; obj_cnt=16320.
- Single nonzero pixel res[(3<<7)+5]=3, rest 0 -> only sti_addr 24 has sti_do=16'h0400; obj_cnt=1. Same pixel with THRESH=4 -> all words 0.
- Timing check: first sti_wr 17 cycles after the start edge, write pulses every 16 cycles, done 16386 cycles after start. A second start mid-pass causes no restart; address sequence is unbroken.
- reset asserted asynchronously mid-READ (e.g. after 5000 cycles) -> all outputs 0 immediately with no further sti_wr. A new start afterwards completes a full correct pass from address 0.

Source files
------------

// File: rtl/res_pack_if.sv
// res_pack_if: res-memory read port, sti-style write port and control/status of res_pack.
interface res_pack_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic [14:0] obj_cnt;
  modport master (
    output start, res_di,
    input  busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_cnt
  );
  modport slave (
    input  start, res_di,
    output busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_cnt
  );
endinterface

// File: rtl/res_pack.sv
// res_pack: thresholds a 128x128 8-bit res map to 1 bit/pixel and packs 16 pixels per sti word.
module res_pack #(
  parameter logic [7:0] THRESH = 8'd1
) (
  input logic       clk,
  input logic       reset,
  res_pack_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH, FINISH} state_t;
  state_t      state, state_n;
  logic        vld;
  logic [3:0]  bcnt;
  logic [14:0] shift;
  logic [9:0]  wcnt;
  logic        px;
  logic        go;
  assign go       = bus.start && (state == IDLE || state == FINISH);
  assign px       = bus.res_di >= THRESH;
  assign bus.busy = state == READ || state == FLUSH;
  assign bus.done = state == FINISH;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // FLUSH ends once the last word's pulse is out and no sample is left in flight
  always_comb begin
    state_n = state;
    state_n = go ? READ :
              (state == READ && bus.res_rd && bus.res_addr == 14'h3fff) ? FLUSH :
              (state == FLUSH && bus.sti_wr && !vld) ? FINISH : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.res_rd   <= 1'b0;
      bus.res_addr <= '0;
      bus.sti_wr   <= 1'b0;
      bus.sti_addr <= '0;
      bus.sti_do   <= '0;
      bus.obj_cnt  <= '0;
      vld          <= 1'b0;
      bcnt         <= '0;
      shift        <= '0;
      wcnt         <= '0;
    end else begin
      vld        <= bus.res_rd;
      bus.sti_wr <= 1'b0;
      if (go) begin
        bus.res_rd   <= 1'b1;
        bus.res_addr <= '0;
        bus.obj_cnt  <= '0;
        bcnt         <= '0;
        shift        <= '0;
        wcnt         <= '0;
      end else if (bus.res_rd) begin
        bus.res_addr <= bus.res_addr + 14'd1;
        if (bus.res_addr == 14'h3fff) bus.res_rd <= 1'b0;
      end
      // earliest pixel lands in bit 15 after 15 further shifts
      if (vld) begin
        shift       <= {shift[13:0], px};
        bus.obj_cnt <= bus.obj_cnt + 15'(px);
        bcnt        <= bcnt + 4'd1;
        if (bcnt == 4'd15) begin
          bus.sti_do   <= {shift, px};
          bus.sti_addr <= wcnt;
          bus.sti_wr   <= 1'b1;
          wcnt         <= wcnt + 10'd1;
        end
      end
    end
  end
endmodule
